// File: rtl/gfx_pkg.sv
// Shared graphics definitions: draw-command modes, plotter states, default
// screen geometry and the palette used by the game framebuffer.
package gfx_pkg;

  localparam logic [1:0] MODE_CLEAR  = 2'd0;
  localparam logic [1:0] MODE_RECT   = 2'd1;
  localparam logic [1:0] MODE_SPRITE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_FINISH = 2'd2
  } plot_state_e;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam logic [2:0] COLOR_BLACK  = 3'b000;
  localparam logic [2:0] COLOR_FLOOR  = 3'b010;
  localparam logic [2:0] COLOR_RED    = 3'b100;
  localparam logic [2:0] COLOR_YELLOW = 3'b110;
  localparam logic [2:0] COLOR_WHITE  = 3'b111;

endpackage

// File: rtl/raster_counter.sv
// Column/row scan counter with a programmable extent. Walks col 0..ext_w-1
// within each row, then advances the row, and flags the final pixel.
module raster_counter #(
  parameter int COL_W = 8,
  parameter int ROW_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic [COL_W-1:0] ext_w_i,
  input  logic [ROW_W-1:0] ext_h_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             endOfRow;

  assign endOfRow = (col_q == (ext_w_i - COL_W'(1)));
  assign last_o   = endOfRow && (row_q == (ext_h_i - ROW_W'(1)));
  assign col_o    = col_q;
  assign row_o    = row_q;

  // Next scan position: clear wins, otherwise wrap col at the row end.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (step_i) begin
      if (endOfRow) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Scan position registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/pixel_plotter.sv
// Command-driven pixel engine: clears the screen, fills rectangles or stamps
// 1-bpp sprites, emitting one clipped (x, y, colour, plot) write per clock.
module pixel_plotter
  import gfx_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int SPR_W    = 8,
  parameter int SPR_H    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [X_W-1:0]         x0,
  input  logic [Y_W-1:0]         y0,
  input  logic [X_W-1:0]         w,
  input  logic [Y_W-1:0]         h,
  input  logic [COLOR_W-1:0]     fg_color,
  input  logic [SPR_W*SPR_H-1:0] sprite_bits,
  input  logic                   abort,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [COLOR_W-1:0]     color,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W = $clog2(SPR_W * SPR_H);

  plot_state_e state_q, state_d;

  logic [X_W-1:0]         originX_q, extW_q;
  logic [Y_W-1:0]         originY_q, extH_q;
  logic [COLOR_W-1:0]     cmdColor_q;
  logic [SPR_W*SPR_H-1:0] bits_q;
  logic                   isSprite_q;

  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [COLOR_W-1:0] color_q;
  logic               plot_q, done_q;

  logic           accept, cntClear, cntStep, lastPixel, emptyRect;
  logic [X_W-1:0] col;
  logic [Y_W-1:0] row;
  logic [X_W:0]   px;
  logic [Y_W:0]   py;
  logic [IDX_W-1:0] sprIdx;
  logic           pixelOn, plot_d;

  assign accept    = (state_q == ST_IDLE) && start;
  assign emptyRect = (mode != MODE_CLEAR) && (mode != MODE_SPRITE) &&
                     ((w == '0) || (h == '0));

  raster_counter #(.COL_W(X_W), .ROW_W(Y_W)) u_raster (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (cntClear),
    .step_i  (cntStep),
    .ext_w_i (extW_q),
    .ext_h_i (extH_q),
    .col_o   (col),
    .row_o   (row),
    .last_o  (lastPixel)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: empty rectangles skip straight to the done pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = emptyRect ? ST_FINISH : ST_DRAW;
      ST_DRAW:   if (abort) state_d = ST_IDLE;
                 else if (lastPixel) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy only while scanning, counter control.
  always_comb begin
    busy     = (state_q == ST_DRAW);
    cntStep  = (state_q == ST_DRAW);
    cntClear = accept;
  end

  // Command latch; CLEAR and SPRITE override the caller's geometry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      originX_q  <= '0;
      originY_q  <= '0;
      extW_q     <= '0;
      extH_q     <= '0;
      cmdColor_q <= '0;
      bits_q     <= '0;
      isSprite_q <= 1'b0;
    end else if (accept) begin
      bits_q <= sprite_bits;
      if (mode == MODE_CLEAR) begin
        originX_q  <= '0;
        originY_q  <= '0;
        extW_q     <= X_W'(SCREEN_W);
        extH_q     <= Y_W'(SCREEN_H);
        cmdColor_q <= '0;
        isSprite_q <= 1'b0;
      end else if (mode == MODE_SPRITE) begin
        originX_q  <= x0;
        originY_q  <= y0;
        extW_q     <= X_W'(SPR_W);
        extH_q     <= Y_W'(SPR_H);
        cmdColor_q <= fg_color;
        isSprite_q <= 1'b1;
      end else begin
        originX_q  <= x0;
        originY_q  <= y0;
        extW_q     <= w;
        extH_q     <= h;
        cmdColor_q <= fg_color;
        isSprite_q <= 1'b0;
      end
    end
  end

  // Pixel generation one bit wider than the screen so clipping never wraps.
  always_comb begin
    px      = {1'b0, originX_q} + {1'b0, col};
    py      = {1'b0, originY_q} + {1'b0, row};
    sprIdx  = IDX_W'(row) * IDX_W'(SPR_W) + IDX_W'(col);
    pixelOn = (state_q == ST_DRAW) &&
              (px < (X_W+1)'(SCREEN_W)) && (py < (Y_W+1)'(SCREEN_H)) &&
              (!isSprite_q || bits_q[sprIdx]);
    plot_d  = pixelOn && !abort;
  end

  // Output registers; coordinates and colour hold while plot is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      plot_q <= plot_d;
      done_q <= (state_q == ST_FINISH);
      if (plot_d) begin
        x_q     <= px[X_W-1:0];
        y_q     <= py[Y_W-1:0];
        color_q <= cmdColor_q;
      end
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign color = color_q;
  assign plot  = plot_q;
  assign done  = done_q;

endmodule

// File: tb/tb_pixel_plotter.sv
// Directed bench for pixel_plotter: each scenario task drives a command and
// checks plotted pixels, handshake timing and clipping against hand values.
module tb_pixel_plotter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  x0;
  logic [6:0]  y0;
  logic [7:0]  w;
  logic [6:0]  h;
  logic [2:0]  fg_color;
  logic [63:0] sprite_bits;
  logic        abort;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  color;
  logic        plot, busy, done;

  int testsRun = 0;
  int testsFailed = 0;

  int plotX [20000];
  int plotY [20000];
  int plotC [20000];

  pixel_plotter #(
    .SCREEN_W(160), .SCREEN_H(120), .X_W(8), .Y_W(7),
    .COLOR_W(3), .SPR_W(8), .SPR_H(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .x0(x0), .y0(y0), .w(w), .h(h), .fg_color(fg_color),
    .sprite_bits(sprite_bits), .abort(abort),
    .x(x), .y(y), .color(color), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Raises start for one cycle (or while busy when holdStart), then logs
  // every plotted pixel by cycle number until done or the budget runs out.
  task automatic applyStimulus(input logic holdStart, input int budget,
                               output int nPlots, output int doneCycle,
                               output int firstPlot);
    nPlots = 0; doneCycle = -1; firstPlot = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (plot) begin
        if (nPlots < 20000) begin
          plotX[nPlots] = int'(x);
          plotY[nPlots] = int'(y);
          plotC[nPlots] = int'(color);
        end
        if (firstPlot < 0) firstPlot = k;
        nPlots++;
      end
      if (!holdStart || !busy) start = 1'b0;
      if (done) begin
        doneCycle = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; abort = 0; mode = 0; x0 = 0; y0 = 0;
    w = 0; h = 0; fg_color = 0; sprite_bits = '0;
    #12;
    testsRun++;
    if ({x, y, color, plot, busy, done} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0", {x, y, color, plot, busy, done});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_clear();
    int seen, nPlots, doneCycle, firstPlot, errs, doneSeen;
    mode = 2'd0; seen = 0; doneSeen = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 1000 && seen < 500; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (plot) seen++;
    end
    #2 reset_n = 1'b0;
    #1;
    testsRun++;
    if ({x, y, color, plot, busy, done} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_outputs: got %h, expected 0", {x, y, color, plot, busy, done});
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || plot) doneSeen++;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done || plot) doneSeen++;
    end
    testsRun++;
    if (doneSeen != 0) begin
      testsFailed++;
      $display("[TB] FAIL reset_no_done: got %0d activity cycles, expected 0", doneSeen);
    end
    mode = 2'd0;
    applyStimulus(1'b0, 19400, nPlots, doneCycle, firstPlot);
    testsRun++;
    if (nPlots != 19200) begin
      testsFailed++;
      $display("[TB] FAIL clear_count: got %0d, expected 19200", nPlots);
    end
    errs = 0;
    for (int i = 0; i < nPlots && i < 20000; i++)
      if (plotX[i] != i % 160 || plotY[i] != i / 160 || plotC[i] != 0) errs++;
    testsRun++;
    if (errs != 0) begin
      testsFailed++;
      $display("[TB] FAIL clear_raster: got %0d bad pixels, expected 0", errs);
    end
    testsRun++;
    if (doneCycle != 19202) begin
      testsFailed++;
      $display("[TB] FAIL clear_done_cycle: got %0d, expected 19202", doneCycle);
    end
  endtask

  task automatic test_rect();
    int nPlots, doneCycle, firstPlot, errs;
    int expX [6] = '{10, 11, 12, 10, 11, 12};
    int expY [6] = '{20, 20, 20, 21, 21, 21};
    mode = 2'd1; x0 = 8'd10; y0 = 7'd20; w = 8'd3; h = 7'd2; fg_color = 3'b110;
    applyStimulus(1'b0, 50, nPlots, doneCycle, firstPlot);
    testsRun++;
    if (nPlots != 6) begin
      testsFailed++;
      $display("[TB] FAIL rect_count: got %0d, expected 6", nPlots);
    end
    errs = 0;
    for (int i = 0; i < 6; i++)
      if (plotX[i] != expX[i] || plotY[i] != expY[i] || plotC[i] != 6) errs++;
    testsRun++;
    if (errs != 0) begin
      testsFailed++;
      $display("[TB] FAIL rect_pixels: got %0d bad pixels, expected 0", errs);
    end
    testsRun++;
    if (firstPlot != 2) begin
      testsFailed++;
      $display("[TB] FAIL rect_first_plot: got cycle %0d, expected 2", firstPlot);
    end
    testsRun++;
    if (doneCycle != 8) begin
      testsFailed++;
      $display("[TB] FAIL rect_done_cycle: got %0d, expected 8", doneCycle);
    end
  endtask

  task automatic test_clip();
    int nPlots, doneCycle, firstPlot;
    int expX [4] = '{158, 159, 158, 159};
    int expY [4] = '{118, 118, 119, 119};
    mode = 2'd3; x0 = 8'd158; y0 = 7'd118; w = 8'd4; h = 7'd4; fg_color = 3'b100;
    applyStimulus(1'b0, 50, nPlots, doneCycle, firstPlot);
    testsRun++;
    if (nPlots != 4) begin
      testsFailed++;
      $display("[TB] FAIL clip_count: got %0d, expected 4", nPlots);
    end
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (plotX[i] != expX[i] || plotY[i] != expY[i]) begin
        testsFailed++;
        $display("[TB] FAIL clip_pixel%0d: got (%0d,%0d), expected (%0d,%0d)",
                 i, plotX[i], plotY[i], expX[i], expY[i]);
      end
    end
    testsRun++;
    if (doneCycle != 18) begin
      testsFailed++;
      $display("[TB] FAIL clip_done_cycle: got %0d, expected 18", doneCycle);
    end
  endtask

  task automatic test_sprite();
    int nPlots, doneCycle, firstPlot, errs, c, r;
    mode = 2'd2; x0 = 8'd25; y0 = 7'd108; w = 8'd0; h = 7'd0; fg_color = 3'b101;
    sprite_bits = 64'hAA55AA55AA55AA55;
    applyStimulus(1'b0, 100, nPlots, doneCycle, firstPlot);
    testsRun++;
    if (nPlots != 32) begin
      testsFailed++;
      $display("[TB] FAIL sprite_count: got %0d, expected 32", nPlots);
    end
    errs = 0;
    for (int i = 0; i < nPlots && i < 64; i++) begin
      c = plotX[i] - 25;
      r = plotY[i] - 108;
      if (c < 0 || c > 7 || r < 0 || r > 7 || ((r + c) % 2) != 0 || plotC[i] != 5) errs++;
    end
    testsRun++;
    if (errs != 0) begin
      testsFailed++;
      $display("[TB] FAIL sprite_pixels: got %0d bad pixels, expected 0", errs);
    end
    testsRun++;
    if (doneCycle != 66) begin
      testsFailed++;
      $display("[TB] FAIL sprite_done_cycle: got %0d, expected 66", doneCycle);
    end
  endtask

  task automatic test_empty_rect();
    int nPlots, doneCycle, firstPlot;
    mode = 2'd1; x0 = 8'd5; y0 = 7'd5; w = 8'd0; h = 7'd3; fg_color = 3'b111;
    applyStimulus(1'b0, 20, nPlots, doneCycle, firstPlot);
    testsRun++;
    if (nPlots != 0) begin
      testsFailed++;
      $display("[TB] FAIL empty_count: got %0d, expected 0", nPlots);
    end
    testsRun++;
    if (doneCycle != 2) begin
      testsFailed++;
      $display("[TB] FAIL empty_done_cycle: got %0d, expected 2", doneCycle);
    end
  endtask

  task automatic test_back_to_back();
    int nPlots, doneCycle, firstPlot, extra;
    mode = 2'd1; x0 = 8'd0; y0 = 7'd0; w = 8'd2; h = 7'd2; fg_color = 3'b010;
    applyStimulus(1'b1, 50, nPlots, doneCycle, firstPlot);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (plot || busy || done) extra++;
    end
    testsRun++;
    if (nPlots != 4 || doneCycle != 6) begin
      testsFailed++;
      $display("[TB] FAIL held_start_cmd: got %0d plots done@%0d, expected 4 plots done@6",
               nPlots, doneCycle);
    end
    testsRun++;
    if (extra != 0) begin
      testsFailed++;
      $display("[TB] FAIL held_start_requeue: got %0d active cycles, expected 0", extra);
    end
  endtask

  task automatic test_abort();
    int nPlots, doneCnt, doneCycle, firstPlot;
    logic busyAfter;
    mode = 2'd1; x0 = 8'd40; y0 = 7'd40; w = 8'd8; h = 7'd8; fg_color = 3'b011;
    nPlots = 0; doneCnt = 0; busyAfter = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (plot) nPlots++;
      if (done) doneCnt++;
      if (k == 6) begin
        busyAfter = busy;
        abort = 1'b0;
      end
      if (k == 5) abort = 1'b1;
    end
    testsRun++;
    if (nPlots < 4 || nPlots > 5) begin
      testsFailed++;
      $display("[TB] FAIL abort_plots: got %0d, expected 4..5", nPlots);
    end
    testsRun++;
    if (doneCnt != 0) begin
      testsFailed++;
      $display("[TB] FAIL abort_no_done: got %0d, expected 0", doneCnt);
    end
    testsRun++;
    if (busyAfter !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abort_busy: got %b, expected 0", busyAfter);
    end
    mode = 2'd1; x0 = 8'd7; y0 = 7'd9; w = 8'd1; h = 7'd1; fg_color = 3'b001;
    applyStimulus(1'b0, 20, nPlots, doneCycle, firstPlot);
    testsRun++;
    if (nPlots != 1 || plotX[0] != 7 || plotY[0] != 9 || plotC[0] != 1 || doneCycle != 3) begin
      testsFailed++;
      $display("[TB] FAIL abort_restart: got %0d plots (%0d,%0d) c%0d done@%0d, expected 1 plot (7,9) c1 done@3",
               nPlots, plotX[0], plotY[0], plotC[0], doneCycle);
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_reset_mid_clear();
    test_rect();
    test_clip();
    test_sprite();
    test_empty_rect();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pixel_plotter.md
Name: pixel_plotter

Overview:
Generic command-driven pixel engine for the VGA game framebuffer. It accepts one draw command at a time: clear screen, solid rectangle, or 1-bpp sprite. It emits one (x, y, colour, plot) write per clock in raster order. It replaces the per-object hard-coded drawing counters with a single parametrised engine, adding clipping, sprite transparency, abort and a start/busy/done handshake.

Parameters:
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels
X_W, 8, x coordinate width; must hold SCREEN_W-1
Y_W, 7, y coordinate width; must hold SCREEN_H-1
COLOR_W, 3, colour width
SPR_W, 8, sprite width in pixels (max 16)
SPR_H, 8, sprite height in pixels (max 16)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  command strobe; sampled only in IDLE
mode  in  2  0 CLEAR, 1 RECT, 2 SPRITE, 3 reserved (treated as RECT)
x0  in  X_W  top-left x (RECT/SPRITE)
y0  in  Y_W  top-left y
w  in  X_W  rectangle width (RECT only)
h  in  Y_W  rectangle height (RECT only)
fg_color  in  COLOR_W  fill / sprite foreground colour
sprite_bits  in  SPR_W*SPR_H  bitmap; row r col c at bit r*SPR_W+c; 1 = opaque
abort  in  1  cancel current command
x  out  X_W  pixel x, registered
y  out  Y_W  pixel y, registered
color  out  COLOR_W  pixel colour, registered
plot  out  1  write enable for x/y/color this cycle
busy  out  1  high from the cycle after start is accepted until return to IDLE
done  out  1  one-cycle pulse after the last pixel of a completed command

Behaviour:
- Reset: state IDLE; x=0, y=0, color=0, plot=0, busy=0, done=0; latched command cleared. Reset is asynchronous, mid-command included, and produces no done.
- States: IDLE, DRAW, FINISH.
- IDLE: on start=1, latch mode, x0, y0, w, h, fg_color and sprite_bits, and zero the col/row counters.
  - CLEAR: origin (0,0), extent SCREEN_W x SCREEN_H, colour 0.
  - SPRITE: extent SPR_W x SPR_H.
  - RECT with w=0 or h=0: go directly to FINISH; no pixels.
  - All other commands: go to DRAW.
- DRAW: each cycle, generate the pixel at (ox+col, oy+row), computed one bit wider than X_W/Y_W so there is no wrap.
  - Outputs register that pixel the next cycle, so the first pixel appears on outputs 2 cycles after the start edge.
  - plot=1 only if px<SCREEN_W, py<SCREEN_H and, in SPRITE mode, sprite bit=1. Suppressed pixels still consume their cycle.
  - col increments each cycle. At col=ext_w-1, col goes to 0 and row increments. At the last pixel (col=ext_w-1, row=ext_h-1), go to FINISH.
  - Cycle count for a command is exactly ext_w*ext_h.
- FINISH: done=1 for one cycle (aligned after the final registered pixel), busy=0, then IDLE.
- busy: 1 in DRAW and FINISH, except that it drops in the FINISH cycle. start while busy is ignored (not queued).
- abort: in DRAW, go to IDLE next cycle. plot is forced 0 that cycle; no done. abort in IDLE or FINISH has no effect.
- start and abort in the same IDLE cycle: start wins.
- plot=0 at all times outside DRAW-generated pixels. x/y/color hold their last value when plot=0.

Decomposition:
- Shared package gfx_pkg holds:
  - mode encodings MODE_CLEAR/MODE_RECT/MODE_SPRITE;
  - state encodings;
  - default screen constants 160/120;
  - floor colour COLOR_FLOOR=3'b010 plus black/white/yellow/red colour constants.
- One natural sub-module: raster_counter (col/row counter with programmable extent, last-pixel flag). It is reused later by the game-over screen generator.

Test Plan:
- Reset mid-CLEAR at pixel 500 -> outputs 0 immediately; no done; next start CLEAR yields exactly 19200 plot pulses (x 0..159, y 0..119 raster) and one done.
- RECT x0=10 y0=20 w=3 h=2 colour 3'b110 -> 6 plots: (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); first 2 cycles after start; done on cycle 8.
- RECT x0=158 y0=118 w=4 h=4 -> 16 cycles; plot only at (158,118),(159,118),(158,119),(159,119); no wrap to x=0.
- SPRITE at (25,108), bits = checkerboard 0xAA55AA55AA55AA55 -> 64 cycles, 32 plots, colours fg only at 1 bits.
- RECT w=0 -> no plot; done 2 cycles after start. start held high during busy -> exactly one command executes.
- abort on 5th DRAW cycle of RECT 8x8 -> ≤5 plots; no done; busy low next cycle; new start accepted.
